// File: rtl/mul_pkg.sv
// Shared constants for the sequential radix-4 Booth multiplier:
// FSM state codes, Booth digit select encodings and width helpers.
package mul_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Booth digit encoding as {neg, dbl, zero}
    localparam logic [2:0] BD_ZERO   = 3'b001;
    localparam logic [2:0] BD_PLUS1  = 3'b000;
    localparam logic [2:0] BD_PLUS2  = 3'b010;
    localparam logic [2:0] BD_MINUS1 = 3'b100;
    localparam logic [2:0] BD_MINUS2 = 3'b110;

    // Extended operand width: two guard bits so unsigned max operands stay exact
    function automatic int ext_width(input int w);
        return w + 2;
    endfunction

    // Step counter width: counts 0 .. E/2-1
    function automatic int step_width(input int w);
        return $clog2((w + 2) / 2);
    endfunction

endpackage

// File: rtl/booth_mul_seq_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a
// {neg, dbl, zero} select for the partial-product adder.
module booth_r4_recode
    import mul_pkg::*;
(
    input  logic [2:0] grp,
    output logic       neg,
    output logic       dbl,
    output logic       zero
);

    logic [2:0] bd;

    // Window -> signed digit in {-2,-1,0,+1,+2}
    always_comb begin
        bd = BD_ZERO;
        case (grp)
            3'b000, 3'b111: bd = BD_ZERO;
            3'b001, 3'b010: bd = BD_PLUS1;
            3'b011:         bd = BD_PLUS2;
            3'b100:         bd = BD_MINUS2;
            3'b101, 3'b110: bd = BD_MINUS1;
            default:        bd = BD_ZERO;
        endcase
    end

    assign {neg, dbl, zero} = bd;

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit per clock.
// Signed/unsigned per operation, valid/ready on both sides.
// Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining
// multiplier bits can only produce zero digits.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int E  = ext_width(WIDTH);
    localparam int AW = 2 * WIDTH + 2;
    localparam int SW = step_width(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(E / 2 - 1);

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [AW-1:0] mcand;
    logic [E:0]    mplr;
    logic [SW-1:0] step;

    logic [E-1:0]  ext_m;
    logic [E-1:0]  ext_q;
    logic [E:0]    mplr_nxt;
    logic [AW-1:0] mag;
    logic [AW-1:0] acc_nxt;
    logic          neg;
    logic          dbl;
    logic          zero;
    logic          calc_end;
    logic          accept;

    assign accept = in_valid & in_ready;

    // Guard bits carry the sign (signed) or zero (unsigned)
    assign ext_m = {{2{in_signed & in_m[WIDTH-1]}}, in_m};
    assign ext_q = {{2{in_signed & in_q[WIDTH-1]}}, in_q};

    booth_r4_recode u_recode (
        .grp  (mplr[2:0]),
        .neg  (neg),
        .dbl  (dbl),
        .zero (zero)
    );

    // Partial product: 0, M or 2M, negated via one's complement plus carry-in
    assign mag      = zero ? '0 : (dbl ? {mcand[AW-2:0], 1'b0} : mcand);
    assign acc_nxt  = acc + (mag ^ {AW{neg}}) + {{(AW-1){1'b0}}, neg};
    assign mplr_nxt = {{2{mplr[E]}}, mplr[E:2]};

`ifdef EARLY_TERM_EN
    // Remaining window all-0 or all-1 means every further digit is zero
    assign calc_end = (step == LAST_STEP) | (&mplr_nxt) | ~(|mplr_nxt);
`else
    assign calc_end = (step == LAST_STEP);
`endif

    // Control FSM: IDLE -> CALC -> DONE -> IDLE
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)    state <= ST_CALC;
                ST_CALC: if (calc_end)  state <= ST_DONE;
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: load operands on accept, retire one digit per CALC cycle
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            step  <= '0;
        end else if (state == ST_IDLE && accept) begin
            acc   <= '0;
            mcand <= {{(AW-E){ext_m[E-1]}}, ext_m};
            mplr  <= {ext_q, 1'b0};
            step  <= '0;
        end else if (state == ST_CALC) begin
            acc   <= acc_nxt;
            mcand <= {mcand[AW-3:0], 2'b00};
            mplr  <= mplr_nxt;
            step  <= step + SW'(1);
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_CALC);
    assign out_p     = out_valid ? acc[2*WIDTH-1:0] : '0;

endmodule
